// File: rtl/clk_monitor_pkg.sv
// Shared types and helpers for the clk_monitor slow-clock receiver.
package clk_monitor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        TRACK
    } state_e;

    // All-ones value of a counter of the given width (width up to 32).
    function automatic logic [31:0] cnt_max(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchroniser with a history flop, giving registered rise/fall strobes.
// The unregistered edge events are also exported so a consumer can act on the same edge.
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_evt_o,
    output logic fall_evt_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   s_sync;

    assign s_sync     = sync_q[SYNC_STAGES-1];
    assign rise_evt_o = s_sync & ~prev_q;
    assign fall_evt_o = ~s_sync & prev_q;
    assign rise_o     = rise_q;
    assign fall_o     = fall_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            prev_q <= s_sync;
            rise_q <= rise_evt_o;
            fall_q <= fall_evt_o;
        end
    end

endmodule

// File: rtl/clk_monitor.sv
// Slow-clock monitor: edge strobes, period/high-time measurement, lock and timeout.
// Define CLK_MONITOR_DUTY_EN to build the high-time capture; otherwise high_time reads 0.
module clk_monitor
    import clk_monitor_pkg::*;
#(
    parameter int CNT_WIDTH   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic                 sig_in,
    output logic                 rise,
    output logic                 fall,
    output logic [CNT_WIDTH-1:0] period,
    output logic [CNT_WIDTH-1:0] high_time,
    output logic                 period_valid,
    output logic                 locked,
    output logic                 timeout
);

    localparam int                   MATCH_W     = $clog2(LOCK_COUNT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = CNT_WIDTH'(cnt_max(CNT_WIDTH));
    localparam logic [MATCH_W-1:0]   LOCK_TARGET = MATCH_W'(LOCK_COUNT);

    logic rise_evt;
    logic fall_evt;

    sync_edge_det #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .sig_i     (sig_in),
        .rise_evt_o(rise_evt),
        .fall_evt_o(fall_evt),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] period_q, period_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic                 valid_q, valid_d;
    logic                 locked_q, locked_d;
    logic                 timeout_q, timeout_d;
    logic                 saturated;

    assign saturated = (cnt_q == CNT_MAX);

    // NOTE: every signal gets its default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        match_d   = match_q;
        valid_d   = valid_q;
        locked_d  = locked_q;
        timeout_d = timeout_q;
        cnt_d     = rise_evt ? CNT_WIDTH'(1) : (saturated ? cnt_q : cnt_q + 1'b1);

        case (state_q)
            IDLE: begin
                if (rise_evt) begin
                    state_d   = MEASURE;
                    timeout_d = 1'b0;
                end
            end
            MEASURE, TRACK: begin
                if (rise_evt && saturated) begin
                    // Overflowed interval: restart from this edge as a fresh reference.
                    state_d = MEASURE;
                end else if (saturated) begin
                    state_d   = IDLE;
                    timeout_d = 1'b1;
                    locked_d  = 1'b0;
                    valid_d   = 1'b0;
                end else if (rise_evt) begin
                    period_d = cnt_q;
                    if (state_q == MEASURE) begin
                        state_d  = TRACK;
                        valid_d  = 1'b1;
                        match_d  = MATCH_W'(1);
                        locked_d = 1'b0;  // match history restarts, so lock must be re-earned
                    end else if (cnt_q == period_q) begin
                        match_d = (match_q >= LOCK_TARGET) ? LOCK_TARGET : match_q + 1'b1;
                        if (match_d == LOCK_TARGET) begin
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_d  = MATCH_W'(1);
                        locked_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            match_q   <= '0;
            valid_q   <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            match_q   <= match_d;
            valid_q   <= valid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

`ifdef CLK_MONITOR_DUTY_EN
    logic [CNT_WIDTH-1:0] high_q, high_d;

    always_comb begin
        high_d = high_q;
        if (fall_evt && (state_q != IDLE)) begin
            high_d = cnt_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            high_q <= '0;
        end else begin
            high_q <= high_d;
        end
    end

    assign high_time = high_q;
`else
    logic unused_fall_evt;
    assign unused_fall_evt = fall_evt;
    assign high_time       = '0;
`endif

endmodule

// File: tb/tb_clk_monitor.sv
// Directed, table-driven bench for clk_monitor (default parameters: 8-bit counters,
// 2 sync stages, lock after 4 equal periods). Expects high_time only with CLK_MONITOR_DUTY_EN.
module tb_clk_monitor;

    logic       clk_in = 1'b0;
    logic       rst_n  = 1'b0;
    logic       sig_in = 1'b0;
    logic       rise;
    logic       fall;
    logic [7:0] period;
    logic [7:0] high_time;
    logic       period_valid;
    logic       locked;
    logic       timeout;

    clk_monitor #(
        .CNT_WIDTH  (8),
        .SYNC_STAGES(2),
        .LOCK_COUNT (4)
    ) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .sig_in      (sig_in),
        .rise        (rise),
        .fall        (fall),
        .period      (period),
        .high_time   (high_time),
        .period_valid(period_valid),
        .locked      (locked),
        .timeout     (timeout)
    );

    always #5 clk_in = ~clk_in;

`ifdef CLK_MONITOR_DUTY_EN
    localparam bit DUTY = 1'b1;
`else
    localparam bit DUTY = 1'b0;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int ht(input int v);
        return DUTY ? v : 0;
    endfunction

    // One record per waveform period: h high cycles then l low cycles. The expected
    // fields are the outputs on the rise that starts this period; its spacing from
    // the previous rise is the previous record's h+l.
    typedef struct {
        int h;
        int l;
        int period;
        bit valid;
        bit locked;
        int high;
        bit timeout;
    } vec_t;

    vec_t vecs[13];

    task automatic apply_vec(input int i);
        string tag;
        tag = $sformatf("v%0d", i);
        for (int c = 0; c < vecs[i].h + vecs[i].l; c++) begin
            sig_in = (c < vecs[i].h);
            @(negedge clk_in);
            if (c == 1) check({tag, " rise_early"}, rise, 0);
            if (c == 2) begin
                check({tag, " rise"}, rise, 1);
                check({tag, " fall_at_rise"}, fall, 0);
                check({tag, " period"}, period, vecs[i].period);
                check({tag, " period_valid"}, period_valid, vecs[i].valid);
                check({tag, " locked"}, locked, vecs[i].locked);
                check({tag, " high_time"}, high_time, ht(vecs[i].high));
                check({tag, " timeout"}, timeout, vecs[i].timeout);
            end
            if (c == 3) check({tag, " rise_one_cycle"}, rise, 0);
            if (c == vecs[i].h + 2) check({tag, " fall"}, fall, 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " rise"}, rise, 0);
        check({tag, " fall"}, fall, 0);
        check({tag, " period"}, period, 0);
        check({tag, " high_time"}, high_time, 0);
        check({tag, " period_valid"}, period_valid, 0);
        check({tag, " locked"}, locked, 0);
        check({tag, " timeout"}, timeout, 0);
    endtask

    initial begin
        int cyc;

        //           h    l  period v  L  high to
        vecs[0]  = '{3,   3,   0,   0, 0, 0,   0};  // first edge from IDLE
        vecs[1]  = '{3,   3,   6,   1, 0, 3,   0};  // valid on 2nd rise
        vecs[2]  = '{3,   3,   6,   1, 0, 3,   0};
        vecs[3]  = '{3,   3,   6,   1, 0, 3,   0};
        vecs[4]  = '{3,   3,   6,   1, 1, 3,   0};  // lock on 5th rise
        vecs[5]  = '{4,   4,   6,   1, 1, 3,   0};  // source switches to divide-by-8
        vecs[6]  = '{4,   4,   8,   1, 0, 4,   0};  // first 8-cycle period drops lock
        vecs[7]  = '{4,   4,   8,   1, 0, 4,   0};
        vecs[8]  = '{4,   4,   8,   1, 0, 4,   0};
        vecs[9]  = '{4, 251,   8,   1, 1, 4,   0};  // relock; next gap is 255 cycles
        vecs[10] = '{3,   3,   8,   1, 1, 4,   0};  // rise at cnt==255: no update
        vecs[11] = '{3,   3,   8,   0, 0, 3,   0};  // IDLE rise after timeout
        vecs[12] = '{3,   3,   6,   1, 0, 3,   0};  // valid back on following rise

        rst_n  = 1'b0;
        sig_in = 1'b0;
        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge clk_in);

        for (int i = 0; i <= 10; i++) apply_vec(i);

        // Hold low after the overflow edge: timeout 255 cycles after that rise.
        cyc = 3;
        while (timeout !== 1'b1 && cyc < 400) begin
            @(negedge clk_in);
            cyc++;
        end
        check("timeout latency", cyc, 255);
        check("timeout flag", timeout, 1);
        check("timeout locked", locked, 0);
        check("timeout period_valid", period_valid, 0);
        check("timeout period_kept", period, 8);
        check("timeout high_time", high_time, ht(3));

        apply_vec(11);
        apply_vec(12);

        // Asynchronous reset while tracking a period of 6.
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk_in);
        rst_n = 1'b1;

        for (int i = 0; i <= 4; i++) apply_vec(i);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/clk_monitor.md
Name: clk_monitor

Overview:
- Receiving end of a divided clock: samples a slow clock or strobe (e.g. a divider output, or an external pixel/tick clock) in the fast clk_in domain.
- Produces single-cycle rise/fall strobes for use as clock enables.
- Measures the signal's period and high time in clk_in cycles, flags lock when the period is stable, and flags timeout when the signal stops toggling.
- Lets downstream logic run on clk_in with enables instead of on a derived clock.

Parameters:
- CNT_WIDTH, 8, width of the period and high-time counters; saturating maximum is 2^CNT_WIDTH-1.
- SYNC_STAGES, 2, synchroniser depth on sig_in; legal values are 2 or more.
- LOCK_COUNT, 4, number of consecutive identical periods needed for lock; legal values are 2 or more.

Ports:
- clk_in  input  1  fast system clock.
- rst_n  input  1  asynchronous active-low reset.
- sig_in  input  1  monitored slow clock, asynchronous to clk_in.
- rise  output  1  one-cycle strobe on each synchronised rising edge.
- fall  output  1  one-cycle strobe on each synchronised falling edge.
- period  output  CNT_WIDTH  last measured rise-to-rise interval, in clk_in cycles.
- high_time  output  CNT_WIDTH  last measured rise-to-fall interval, in clk_in cycles.
- period_valid  output  1  period holds a real measurement.
- locked  output  1  last LOCK_COUNT periods were identical.
- timeout  output  1  counter saturated with no rise seen.

Behaviour:
- Interface: one clock, clk_in; reset is asynchronous active-low, rst_n.
- Reset: all outputs go to 0 immediately. Synchroniser flops, edge-history flop and counter go to 0. State goes to IDLE. Reset mid-measurement discards everything.
- Synchroniser:
  - SYNC_STAGES flops, followed by one history flop.
  - rise = s_sync & ~s_prev; fall = ~s_sync & s_prev. Both are registered.
  - rise goes high exactly SYNC_STAGES+1 clk_in edges after the first edge that samples sig_in high, and stays high for 1 cycle. fall behaves the same way.
  - A pulse shorter than 1 clk_in cycle may be lost; this is accepted.
- Counter cnt:
  - On a rise event, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at all-ones.
  - Evenly spaced rise events N cycles apart therefore read cnt == N at the second event.
- States:
  - IDLE: no reference edge yet. On a rise event, go to MEASURE; timeout <= 0.
  - MEASURE: on a rise event with cnt < max, period <= cnt, period_valid <= 1, match <= 1, go to TRACK.
  - TRACK: on a rise event with cnt < max, period <= cnt.
    - If cnt == previous period, match <= sat(match+1). Otherwise match <= 1 and locked <= 0.
    - locked <= 1 once match reaches LOCK_COUNT.
    - With steady input, locked rises on the edge that processes the (LOCK_COUNT+1)th rise event.
- Saturation: in MEASURE or TRACK, cnt reaching all-ones with no rise event sets:
  - timeout <= 1, locked <= 0, period_valid <= 0, state <= IDLE.
  - period keeps its last value.
- Simultaneous events:
  - A rise event in the same cycle that cnt equals all-ones is an overflow, not a measurement. It is treated as a first reference edge: state goes to MEASURE, and period and locked are not updated.
  - A rise event in IDLE clears timeout.
- high_time: on a fall event in MEASURE or TRACK, high_time <= cnt. A fall event in IDLE is ignored.
- Output timing: period, period_valid and locked update on the same edge that asserts rise.

Optional Feature:
- Macro: CLK_MONITOR_DUTY_EN.
- Defined: high_time is captured as described in Behaviour.
- Undefined: the high_time register is not built and high_time is tied to 0. The fall strobe remains.

Decomposition:
- Package clk_monitor_pkg holds:
  - the state enum: IDLE, MEASURE, TRACK;
  - a function or constant for counter saturation (all-ones of CNT_WIDTH).
- One sub-module, sync_edge_det: SYNC_STAGES synchroniser plus history flop, producing rise and fall. It is reusable for other asynchronous inputs such as buttons.

Test Plan:
- Reset and synchroniser latency: hold rst_n low, then release. All outputs are 0. Raise sig_in → rise goes high exactly 3 edges later (SYNC_STAGES=2) for 1 cycle; period_valid stays 0.
- Steady input, lock: drive sig_in from a divide-by-6 source (3 high, 3 low) → period=6, high_time=3. period_valid is set on the 2nd rise; locked is set on the 5th rise and stays high.
- Period change: after lock, change the source to divide-by-8 → on the first 8-cycle rise, period=8 and locked=0. locked returns to 1 after 4 consecutive 8-cycle periods.
- Timeout: after lock, hold sig_in low → timeout=1, locked=0, period_valid=0 when cnt reaches 255. The next rise clears timeout, and period_valid returns on the rise after that.
- Reset mid-operation: pulse rst_n low for 1 cycle while in TRACK with period=6 → all outputs are 0 at once. Relock follows the same sequence as the steady-input test.
- Macro off: build without CLK_MONITOR_DUTY_EN and repeat the steady-input test → high_time=0 at all times; rise, fall and period behave the same as with the macro defined.
